// File: rtl/memory_port_arbiter.sv
// Shares one memory group between instruction fetch and load/store. LSU has
// priority, IF is forced through after MAX_CONSEC LSU wins, reads return after READ_LATENCY.
module memory_port_arbiter #(
  parameter int  DATA_DEPTH   = 4096,
  parameter int  READ_LATENCY = 2,
  parameter int  MAX_CONSEC   = 4,
  localparam int ADDR_W       = 2 + $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_we,
  input  logic [1:0]        lsu_req_width,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [31:0]       lsu_req_wdata,
  output logic              lsu_rsp_valid,
  output logic [31:0]       lsu_rsp_data,
  output logic              mem_we,
  output logic [1:0]        mem_data_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam logic [1:0] WIDTH_WORD = 2'd2;
  localparam int CNT_W = $clog2(MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CONSEC_LIMIT = CNT_W'(MAX_CONSEC);

  logic [CNT_W-1:0]        consec_q, consec_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_own_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [1:0]              width_q;
  logic [31:0]             wdata_q;
  logic [31:0]             if_data_q, lsu_data_q;
  logic                    force_if, grant_lsu, grant_if, issue_rd;
  logic                    rsp_vld, rsp_lsu;

  always_comb begin
    force_if  = if_req_valid && (consec_q == CONSEC_LIMIT);
    grant_lsu = lsu_req_valid && !force_if;
    grant_if  = if_req_valid && !grant_lsu;
    issue_rd  = grant_if || (grant_lsu && !lsu_req_we);
  end

  assign if_req_ready  = grant_if;
  assign lsu_req_ready = grant_lsu;

  // Counts LSU wins only while IF is actually waiting.
  always_comb begin
    consec_d = '0;
    if (grant_lsu && if_req_valid) begin
      if (consec_q != CONSEC_LIMIT) consec_d = consec_q + CNT_W'(1);
      else                          consec_d = consec_q;
    end
  end

  // With no grant the memory sees the last command's address/width again.
  always_comb begin
    mem_we         = 1'b0;
    mem_data_width = width_q;
    mem_addr       = addr_q;
    mem_write_data = wdata_q;
    if (grant_lsu) begin
      mem_we         = lsu_req_we;
      mem_data_width = lsu_req_width;
      mem_addr       = lsu_req_addr;
      mem_write_data = lsu_req_wdata;
    end else if (grant_if) begin
      mem_data_width = WIDTH_WORD;
      mem_addr       = if_req_addr;
    end
  end

  always_comb begin
    rsp_vld       = pipe_vld_q[READ_LATENCY-1];
    rsp_lsu       = pipe_own_q[READ_LATENCY-1];
    if_rsp_valid  = rsp_vld && !rsp_lsu;
    lsu_rsp_valid = rsp_vld && rsp_lsu;
    if_rsp_data   = if_rsp_valid  ? mem_read_data : if_data_q;
    lsu_rsp_data  = lsu_rsp_valid ? mem_read_data : lsu_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consec_q   <= '0;
      pipe_vld_q <= '0;
      pipe_own_q <= '0;
      addr_q     <= '0;
      width_q    <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      lsu_data_q <= '0;
    end else begin
      consec_q      <= consec_d;
      pipe_vld_q[0] <= issue_rd;
      pipe_own_q[0] <= grant_lsu;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_own_q[i] <= pipe_own_q[i-1];
      end
      addr_q     <= mem_addr;
      width_q    <= mem_data_width;
      wdata_q    <= mem_write_data;
      if_data_q  <= if_rsp_data;
      lsu_data_q <= lsu_rsp_data;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: byte-addressed memory group model, a per-cycle
// reference model of grants/responses, and directed scenarios with literal expectations.
module tb_memory_port_arbiter;

  localparam int DATA_DEPTH = 4096;
  localparam int RL         = 2;
  localparam int MAXC       = 4;
  localparam int AW         = 2 + $clog2(DATA_DEPTH);
  localparam int MEM_BYTES  = 1 << AW;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_WORD = 2'd2;

  logic          clk, rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_rsp_valid;
  logic [31:0]   if_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_we;
  logic [1:0]    lsu_req_width;
  logic [AW-1:0] lsu_req_addr;
  logic [31:0]   lsu_req_wdata;
  logic          lsu_rsp_valid;
  logic [31:0]   lsu_rsp_data;
  logic          mem_we;
  logic [1:0]    mem_data_width;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  memory_port_arbiter #(
    .DATA_DEPTH(DATA_DEPTH), .READ_LATENCY(RL), .MAX_CONSEC(MAXC)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_width(lsu_req_width), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_we(mem_we), .mem_data_width(mem_data_width), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    if (w == 2'd0) return 1;
    if (w == 2'd1) return 2;
    return 4;
  endfunction

  // Memory group: write-first, raw little-endian word read at any byte address.
  logic [7:0]  grp_mem [MEM_BYTES];
  logic [31:0] grp_rd1, grp_w;
  always @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < nbytes(mem_data_width); k++)
        grp_mem[(int'(mem_addr) + k) % MEM_BYTES] = mem_write_data[8*k +: 8];
    for (int k = 0; k < 4; k++)
      grp_w[8*k +: 8] = grp_mem[(int'(mem_addr) + k) % MEM_BYTES];
    grp_rd1       <= grp_w;
    mem_read_data <= grp_rd1;
  end

  // Reference model: expected-response queue plus a shadow memory fed by requests.
  typedef struct { int due; bit lsu; logic [31:0] data; } rsp_t;
  rsp_t        expq[$];
  logic [7:0]  shadow [MEM_BYTES];
  int          cyc = 0;
  int          streak = 0;
  logic [31:0] exp_if_data, exp_lsu_data;
  logic [AW-1:0] hold_addr;
  logic [1:0]  hold_width;
  bit          gl, gi, hit_if, hit_lsu;
  rsp_t        ent;

  function automatic logic [31:0] shadow_word(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = shadow[(int'(a) + k) % MEM_BYTES];
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      streak       = 0;
      hold_addr    = '0;
      hold_width   = '0;
      exp_if_data  = '0;
      exp_lsu_data = '0;
      chk("m_rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
      chk("m_rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
      chk("m_rst_if_rsp_data", if_rsp_data, 32'd0);
      chk("m_rst_lsu_rsp_data", lsu_rsp_data, 32'd0);
    end else begin
      gl = lsu_req_valid && !(if_req_valid && streak >= MAXC);
      gi = if_req_valid && !gl;
      chk("m_lsu_ready", 32'(lsu_req_ready), 32'(gl));
      chk("m_if_ready", 32'(if_req_ready), 32'(gi));
      if (gl) begin
        chk("m_mem_we", 32'(mem_we), 32'(lsu_req_we));
        chk("m_mem_width", 32'(mem_data_width), 32'(lsu_req_width));
        chk("m_mem_addr", 32'(mem_addr), 32'(lsu_req_addr));
        chk("m_mem_wdata", mem_write_data, lsu_req_wdata);
      end else if (gi) begin
        chk("m_mem_we", 32'(mem_we), 32'd0);
        chk("m_mem_width", 32'(mem_data_width), 32'(W_WORD));
        chk("m_mem_addr", 32'(mem_addr), 32'(if_req_addr));
      end else begin
        chk("m_mem_we_idle", 32'(mem_we), 32'd0);
        chk("m_mem_width_idle", 32'(mem_data_width), 32'(hold_width));
        chk("m_mem_addr_idle", 32'(mem_addr), 32'(hold_addr));
      end
      hit_if  = 1'b0;
      hit_lsu = 1'b0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
        ent = expq.pop_front();
        if (ent.lsu) begin hit_lsu = 1'b1; exp_lsu_data = ent.data; end
        else         begin hit_if  = 1'b1; exp_if_data  = ent.data; end
      end
      chk("m_if_rsp_valid", 32'(if_rsp_valid), 32'(hit_if));
      chk("m_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(hit_lsu));
      chk("m_if_rsp_data", if_rsp_data, exp_if_data);
      chk("m_lsu_rsp_data", lsu_rsp_data, exp_lsu_data);
      if (gl && lsu_req_we)
        for (int k = 0; k < nbytes(lsu_req_width); k++)
          shadow[(int'(lsu_req_addr) + k) % MEM_BYTES] = lsu_req_wdata[8*k +: 8];
      if (gi || (gl && !lsu_req_we)) begin
        ent.due  = cyc + RL;
        ent.lsu  = gl;
        ent.data = shadow_word(gl ? lsu_req_addr : if_req_addr);
        expq.push_back(ent);
      end
      streak = (gl && if_req_valid) ? streak + 1 : 0;
      if (gl) begin
        hold_addr  = lsu_req_addr;
        hold_width = lsu_req_width;
      end else if (gi) begin
        hold_addr  = if_req_addr;
        hold_width = W_WORD;
      end
    end
    cyc++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
  endtask

  task automatic lsu_load(input logic [AW-1:0] a);
    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b0;
    lsu_req_width = W_WORD;
    lsu_req_addr  = a;
  endtask

  logic [9:0]    pat;
  logic [15:0]   obs;
  logic [AW-1:0] ifa;
  int            pulses;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    if_req_addr = '0; lsu_req_addr = '0; lsu_req_width = W_WORD; lsu_req_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) grp_mem[i] = 8'(i) ^ 8'hA5;
    {grp_mem[3], grp_mem[2], grp_mem[1], grp_mem[0]}     = 32'h11223344;
    {grp_mem[19], grp_mem[18], grp_mem[17], grp_mem[16]} = 32'hDEADBEEF;
    for (int i = 0; i < MEM_BYTES; i++) shadow[i] = grp_mem[i];

    @(negedge clk);
    chk("reset_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("reset_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    chk("reset_if_rsp_data", if_rsp_data, 32'd0);
    chk("reset_lsu_rsp_data", lsu_rsp_data, 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // IF alone: grant at N, data at N+2
    next(); if_req_valid = 1'b1; if_req_addr = AW'(32'h10);
    @(negedge clk); chk("if_alone_ready", 32'(if_req_ready), 32'd1);
    next(); idle();
    @(negedge clk); chk("if_alone_early", 32'(if_rsp_valid), 32'd0);
    @(negedge clk);
    chk("if_alone_valid", 32'(if_rsp_valid), 32'd1);
    chk("if_alone_data", if_rsp_data, 32'hDEADBEEF);

    // Reset while a read is in flight
    next(); if_req_valid = 1'b1; if_req_addr = AW'(32'h20);
    @(negedge clk); chk("rstmid_ready", 32'(if_req_ready), 32'd1);
    next(); idle(); rst = 1'b1;
    @(negedge clk); chk("rstmid_data_zero", if_rsp_data, 32'd0);
    next(); rst = 1'b0;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (if_rsp_valid) pulses++; end
    chk("rstmid_no_pulse", 32'(pulses), 32'd0);

    // Both requesting: LSU wins until the starvation bound forces IF
    ifa = AW'(32'h100);
    for (int i = 0; i < 10; i++) begin
      next();
      if_req_valid = 1'b1; if_req_addr = ifa;
      lsu_load(AW'(32'h200 + 4*i));
      @(negedge clk);
      pat[9-i] = lsu_req_ready;
      if (if_req_ready) ifa = ifa + AW'(4);
    end
    chk("starve_pattern", 32'(pat), 32'(10'b1111011110));

    // IF dropping out clears the streak
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      next();
      if_req_valid = (i != 3); if_req_addr = AW'(32'h180);
      lsu_load(AW'(32'h240 + 4*i));
      @(negedge clk);
      if (if_req_ready) pulses++;
    end
    chk("streak_clear_if_grants", 32'(pulses), 32'd0);
    next(); idle();
    repeat (3) @(negedge clk);

    // SB then LW of the same word: write-first
    next(); lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_width = W_BYTE;
    lsu_req_addr = AW'(32'h3); lsu_req_wdata = 32'h000000AB;
    @(negedge clk); chk("sb_ready", 32'(lsu_req_ready), 32'd1);
    next(); lsu_load(AW'(32'h0));
    @(negedge clk); chk("lw_ready", 32'(lsu_req_ready), 32'd1);
    next(); idle();
    @(negedge clk);
    @(negedge clk);
    chk("sb_lw_valid", 32'(lsu_rsp_valid), 32'd1);
    chk("sb_lw_data", lsu_rsp_data, 32'hAB223344);
    chk("sb_lw_no_if", 32'(if_rsp_valid), 32'd0);

    // Misaligned SW then LW across a word boundary
    next(); lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_width = W_WORD;
    lsu_req_addr = AW'(32'h5); lsu_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    next(); lsu_load(AW'(32'h5));
    @(negedge clk);
    next(); idle();
    @(negedge clk);
    @(negedge clk);
    chk("mis_lw_valid", 32'(lsu_rsp_valid), 32'd1);
    chk("mis_lw_data", lsu_rsp_data, 32'hCAFEF00D);
    chk("mis_bytes", {grp_mem[8], grp_mem[7], grp_mem[6], grp_mem[5]}, 32'hCAFEF00D);
    chk("mis_byte4_kept", 32'(grp_mem[4]), 32'h000000A1);
    chk("mis_byte9_kept", 32'(grp_mem[9]), 32'h000000AC);

    // Alternating IF / LSU reads: responses back-to-back, in order
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      next();
      idle();
      if (i < 6) begin
        if (i % 2 == 0) begin if_req_valid = 1'b1; if_req_addr = AW'(32'h300 + 4*i); end
        else lsu_load(AW'(32'h400 + 4*i));
      end
      @(negedge clk);
      obs = {obs[13:0], lsu_rsp_valid, if_rsp_valid};
    end
    chk("alt_sequence", 32'(obs), 32'h0000_0666);

    next(); idle();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
